cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between the two writeback producers, the ALU and the LSB.
- Each producer feeds a small per-source FIFO. A round-robin arbiter grants one head per cycle onto a registered CDB.
- The registered CDB output drives the valid/alias/result inputs of the reservation station, the LSB and the ROB.
- Replaces the current scheme where consumers snoop two separate result buses.

---
 rtl/cdb_arbiter.sv | 177 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs (ALU, LSB) drained round-robin onto a registered CDB.
// Optional same-edge bypass of an empty FIFO is enabled by defining CDB_BYPASS_EN.
module cdb_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ALIAS_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   rollback_from_rob,
    input  logic                   valid_from_alu,
    input  logic [ALIAS_WIDTH-1:0] alias_from_alu,
    input  logic [DATA_WIDTH-1:0]  result_from_alu,
    output logic                   ready_to_alu,
    input  logic                   valid_from_lsb,
    input  logic [ALIAS_WIDTH-1:0] alias_from_lsb,
    input  logic [DATA_WIDTH-1:0]  result_from_lsb,
    output logic                   ready_to_lsb,
    output logic                   cdb_valid,
    output logic [ALIAS_WIDTH-1:0] cdb_alias,
    output logic [DATA_WIDTH-1:0]  cdb_result,
    output logic                   cdb_src
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NSRC  = 2;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [ALIAS_WIDTH-1:0] tag;
        logic [DATA_WIDTH-1:0]  value;
    } entry_t;

    // Source index 0 is the ALU, 1 is the LSB throughout.
    entry_t                 mem_q    [NSRC][FIFO_DEPTH];
    entry_t                 mem_d    [NSRC][FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q [NSRC];
    logic [PTR_W-1:0]       wr_ptr_d [NSRC];
    logic [PTR_W-1:0]       rd_ptr_q [NSRC];
    logic [PTR_W-1:0]       rd_ptr_d [NSRC];
    logic [CNT_W-1:0]       count_q  [NSRC];
    logic [CNT_W-1:0]       count_d  [NSRC];
    logic                   last_grant_q, last_grant_d;
    logic                   cdb_valid_q, cdb_valid_d;
    logic [ALIAS_WIDTH-1:0] cdb_alias_q, cdb_alias_d;
    logic [DATA_WIDTH-1:0]  cdb_result_q, cdb_result_d;
    logic                   cdb_src_q, cdb_src_d;

    entry_t                 in_entry [NSRC];
    entry_t                 head     [NSRC];
    logic [NSRC-1:0]        in_valid;
    logic [NSRC-1:0]        in_ok;
    logic [NSRC-1:0]        not_empty;
    logic [NSRC-1:0]        src_ready;
    logic [NSRC-1:0]        byp_cand;
    logic [NSRC-1:0]        cand;
    logic [NSRC-1:0]        bypassed;
    logic [NSRC-1:0]        push;
    logic [NSRC-1:0]        pop;
    logic                   grant_valid;
    logic                   grant_src;
    entry_t                 grant_entry;

    // Round-robin arbitration over FIFO heads (and bypass candidates when enabled).
    always_comb begin
        in_valid    = {valid_from_lsb, valid_from_alu};
        in_entry[0] = '{tag: alias_from_alu, value: result_from_alu};
        in_entry[1] = '{tag: alias_from_lsb, value: result_from_lsb};
        for (int unsigned s = 0; s < NSRC; s++) begin
            src_ready[s] = rdy && (count_q[s] < DEPTH_CNT);
            not_empty[s] = (count_q[s] != '0);
            head[s]      = mem_q[s][rd_ptr_q[s]];
            in_ok[s]     = in_valid[s] && (in_entry[s].tag != '0);
`ifdef CDB_BYPASS_EN
            byp_cand[s]  = rdy && !rollback_from_rob && !not_empty[s] && in_ok[s];
`else
            byp_cand[s]  = 1'b0;
`endif
            cand[s]      = rdy && !rollback_from_rob && (not_empty[s] || byp_cand[s]);
        end
        grant_valid = |cand;
        grant_src   = (&cand) ? ~last_grant_q : cand[1];
        for (int unsigned s = 0; s < NSRC; s++) begin
            bypassed[s] = grant_valid && (grant_src == 1'(s)) && byp_cand[s];
            pop[s]      = grant_valid && (grant_src == 1'(s)) && not_empty[s];
            // A losing bypass candidate falls back to a normal enqueue.
            push[s]     = src_ready[s] && in_ok[s] && !rollback_from_rob && !bypassed[s];
        end
        grant_entry = bypassed[grant_src] ? in_entry[grant_src] : head[grant_src];
    end

    assign ready_to_alu = src_ready[0];
    assign ready_to_lsb = src_ready[1];

    // Next-state: rollback flushes regardless of rdy; rdy low freezes everything else.
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        cdb_valid_d  = cdb_valid_q;
        cdb_alias_d  = cdb_alias_q;
        cdb_result_d = cdb_result_q;
        cdb_src_d    = cdb_src_q;
        if (rollback_from_rob) begin
            for (int unsigned s = 0; s < NSRC; s++) begin
                wr_ptr_d[s] = '0;
                rd_ptr_d[s] = '0;
                count_d[s]  = '0;
            end
            cdb_valid_d = 1'b0;
            cdb_alias_d = '0;
        end else if (rdy) begin
            for (int unsigned s = 0; s < NSRC; s++) begin
                if (push[s]) begin
                    mem_d[s][wr_ptr_q[s]] = in_entry[s];
                    wr_ptr_d[s]           = wr_ptr_q[s] + PTR_W'(1);
                end
                if (pop[s]) begin
                    rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
                end
                case ({push[s], pop[s]})
                    2'b10:   count_d[s] = count_q[s] + CNT_W'(1);
                    2'b01:   count_d[s] = count_q[s] - CNT_W'(1);
                    default: count_d[s] = count_q[s];
                endcase
            end
            if (grant_valid) begin
                cdb_valid_d  = 1'b1;
                cdb_alias_d  = grant_entry.tag;
                cdb_result_d = grant_entry.value;
                cdb_src_d    = grant_src;
                last_grant_d = grant_src;
            end else begin
                cdb_valid_d = 1'b0;
                cdb_alias_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned s = 0; s < NSRC; s++) begin
                for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                    mem_q[s][i] <= '0;
                end
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                count_q[s]  <= '0;
            end
            last_grant_q <= 1'b1;
            cdb_valid_q  <= 1'b0;
            cdb_alias_q  <= '0;
            cdb_result_q <= '0;
            cdb_src_q    <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_alias_q  <= cdb_alias_d;
            cdb_result_q <= cdb_result_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign cdb_valid  = cdb_valid_q;
    assign cdb_alias  = cdb_alias_q;
    assign cdb_result = cdb_result_q;
    assign cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: tests queue expected broadcasts, a monitor pops and compares them.
module tb_cdb_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 4;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int LAT = BYP ? 1 : 2;

    logic          clk;
    logic          rst;
    logic          rdy;
    logic          rollback_from_rob;
    logic          valid_from_alu;
    logic [AW-1:0] alias_from_alu;
    logic [DW-1:0] result_from_alu;
    logic          ready_to_alu;
    logic          valid_from_lsb;
    logic [AW-1:0] alias_from_lsb;
    logic [DW-1:0] result_from_lsb;
    logic          ready_to_lsb;
    logic          cdb_valid;
    logic [AW-1:0] cdb_alias;
    logic [DW-1:0] cdb_result;
    logic          cdb_src;

    cdb_arbiter #(.DATA_WIDTH(DW), .ALIAS_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback_from_rob(rollback_from_rob),
        .valid_from_alu(valid_from_alu), .alias_from_alu(alias_from_alu),
        .result_from_alu(result_from_alu), .ready_to_alu(ready_to_alu),
        .valid_from_lsb(valid_from_lsb), .alias_from_lsb(alias_from_lsb),
        .result_from_lsb(result_from_lsb), .ready_to_lsb(ready_to_lsb),
        .cdb_valid(cdb_valid), .cdb_alias(cdb_alias), .cdb_result(cdb_result), .cdb_src(cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] r;
        logic          s;
    } exp_t;

    exp_t          sb[$];
    int            total;
    int            bad;
    int            acc_a, acc_l, bc_a, bc_l;
    bit            prev_bcast;
    logic [AW-1:0] last_alias;
    logic [DW-1:0] last_result;
    bit            saw_full_a, saw_full_l;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_bcast(input logic [AW-1:0] a, input logic [DW-1:0] r, input logic s);
        exp_t e;
        e.a = a;
        e.r = r;
        e.s = s;
        sb.push_back(e);
    endtask

    // Monitor: one broadcast per active edge, holds while rdy is low, clears on reset/rollback.
    always @(posedge clk) begin : mon_p
        logic r_s, rn_s, rb_s;
        exp_t e;
        r_s  = rdy;
        rn_s = rst;
        rb_s = rollback_from_rob;
        #1;
        if (!rn_s) begin
            prev_bcast  = 1'b0;
            last_result = '0;
        end else if (rb_s) begin
            check("rollback_valid", 64'(cdb_valid), 64'(1'b0));
            check("rollback_alias", 64'(cdb_alias), 64'(0));
            prev_bcast = 1'b0;
        end else if (!r_s) begin
            check("hold_valid", 64'(cdb_valid), 64'(prev_bcast));
            if (prev_bcast) check("hold_alias", 64'(cdb_alias), 64'(last_alias));
            check("hold_result", 64'(cdb_result), 64'(last_result));
        end else if (cdb_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_bcast: got alias %0d result 0x%0h src %0d, expected none (t=%0t)",
                         cdb_alias, cdb_result, cdb_src, $time);
            end else begin
                e = sb.pop_front();
                check("bcast_alias", 64'(cdb_alias), 64'(e.a));
                check("bcast_result", 64'(cdb_result), 64'(e.r));
                check("bcast_src", 64'(cdb_src), 64'(e.s));
                if (e.s) bc_l++;
                else bc_a++;
                last_alias  = e.a;
                last_result = e.r;
            end
            prev_bcast = 1'b1;
        end else begin
            check("idle_alias", 64'(cdb_alias), 64'(0));
            prev_bcast = 1'b0;
        end
    end

    bit flush_pend;

    // One clock of stimulus; checks ready against the bench's outstanding-entry count.
    task automatic cycle(input bit va, input logic [AW-1:0] aa, input logic [DW-1:0] ra,
                         input bit vl, input logic [AW-1:0] al, input logic [DW-1:0] rl,
                         input bit rdy_i, input bit rb_i, output bit ok_a, output bit ok_l);
        @(posedge clk);
        #1;
        rdy               = rdy_i;
        rollback_from_rob = rb_i;
        #1;
        if (flush_pend) begin
            acc_a      = bc_a;
            acc_l      = bc_l;
            flush_pend = 1'b0;
        end
        check("ready_alu", 64'(ready_to_alu), 64'(rdy_i && ((acc_a - bc_a) < int'(DEPTH))));
        check("ready_lsb", 64'(ready_to_lsb), 64'(rdy_i && ((acc_l - bc_l) < int'(DEPTH))));
        if (rdy_i && !ready_to_alu) saw_full_a = 1'b1;
        if (rdy_i && !ready_to_lsb) saw_full_l = 1'b1;
        ok_a = va && ready_to_alu;
        ok_l = vl && ready_to_lsb;
        if (ok_a && aa != '0 && !rb_i) acc_a++;
        if (ok_l && al != '0 && !rb_i) acc_l++;
        if (rb_i) flush_pend = 1'b1;
        valid_from_alu  = va;
        alias_from_alu  = aa;
        result_from_alu = ra;
        valid_from_lsb  = vl;
        alias_from_lsb  = al;
        result_from_lsb = rl;
    endtask

    task automatic idle(input int n);
        bit oa, ol;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, oa, ol);
    endtask

    task automatic drain(input string name, input int n);
        idle(n);
        check(name, 64'(sb.size()), 64'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy = 1'b0;
        rollback_from_rob = 1'b0;
        valid_from_alu = 1'b0;
        valid_from_lsb = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_valid", 64'(cdb_valid), 64'(1'b0));
        check("reset_alias", 64'(cdb_alias), 64'(0));
        check("reset_result", 64'(cdb_result), 64'(0));
        check("reset_src", 64'(cdb_src), 64'(1'b0));
        rst = 1'b1;
        rdy = 1'b1;
        acc_a = bc_a;
        acc_l = bc_l;
        flush_pend = 1'b0;
        saw_full_a = 1'b0;
        saw_full_l = 1'b0;
        #1;
        check("reset_ready_alu", 64'(ready_to_alu), 64'(1'b1));
        check("reset_ready_lsb", 64'(ready_to_lsb), 64'(1'b1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim_p
        bit oa, ol;
        int ia, il;
        rst = 1'b0;
        rdy = 1'b0;
        rollback_from_rob = 1'b0;
        valid_from_alu = 1'b0;
        alias_from_alu = '0;
        result_from_alu = '0;
        valid_from_lsb = 1'b0;
        alias_from_lsb = '0;
        result_from_lsb = '0;
        total = 0;
        bad = 0;

        // Reset state
        do_reset();

        // Single ALU result: latency and one-cycle pulse
        expect_bcast(4'd3, 32'h11, 1'b0);
        cycle(1'b1, 4'd3, 32'h11, 1'b0, '0, '0, 1'b1, 1'b0, oa, ol);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, oa, ol);
            check($sformatf("latency_valid_%0d", i), 64'(cdb_valid), 64'(i == LAT - 1));
        end
        drain("single_drained", 2);

        // Both sources every cycle: strict alternation starting with the ALU
        do_reset();
        expect_bcast(4'd1, 32'h101, 1'b0);
        expect_bcast(4'd5, 32'h105, 1'b1);
        expect_bcast(4'd2, 32'h102, 1'b0);
        expect_bcast(4'd6, 32'h106, 1'b1);
        expect_bcast(4'd3, 32'h103, 1'b0);
        expect_bcast(4'd7, 32'h107, 1'b1);
        for (int k = 1; k <= 3; k++)
            cycle(1'b1, 4'(k), 32'h100 + 32'(k), 1'b1, 4'(k + 4), 32'h104 + 32'(k), 1'b1, 1'b0, oa, ol);
        drain("dual_drained", 10);

        // Backpressured stream with rdy dropped mid-stream
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            expect_bcast(4'(k), 32'hA00 + 32'(k), 1'b0);
            expect_bcast(4'(k) | 4'h8, 32'hB00 + 32'(k), 1'b1);
        end
        ia = 1;
        il = 1;
        for (int c = 0; c < 60 && (ia <= 8 || il <= 8); c++) begin
            cycle(ia <= 8, 4'(ia), 32'hA00 + 32'(ia), il <= 8, 4'(il) | 4'h8, 32'hB00 + 32'(il),
                  !(c == 3 || c == 4), 1'b0, oa, ol);
            if (oa) ia++;
            if (ol) il++;
        end
        check("stream_alu_accepted", 64'(ia), 64'(9));
        check("stream_lsb_accepted", 64'(il), 64'(9));
        drain("stream_drained", 24);
        check("alu_full_seen", 64'(saw_full_a), 64'(1'b1));

        // Rollback with fresh inputs in the same cycle
        do_reset();
        expect_bcast(4'd1, 32'hC01, 1'b0);
        expect_bcast(4'd9, 32'hD01, 1'b1);
        if (BYP) expect_bcast(4'd2, 32'hC02, 1'b0);
        for (int k = 1; k <= 3; k++)
            cycle(1'b1, 4'(k), 32'hC00 + 32'(k), 1'b1, 4'(k + 8), 32'hD00 + 32'(k), 1'b1, 1'b0, oa, ol);
        cycle(1'b1, 4'd12, 32'hDEAD, 1'b1, 4'd13, 32'hBEEF, 1'b1, 1'b1, oa, ol);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, oa, ol);
        check("post_rollback_valid", 64'(cdb_valid), 64'(1'b0));
        drain("rollback_drained", 6);
        // Round-robin pointer survives rollback
        if (BYP) begin
            expect_bcast(4'd14, 32'hF01, 1'b1);
            expect_bcast(4'd4, 32'hE01, 1'b0);
        end else begin
            expect_bcast(4'd4, 32'hE01, 1'b0);
            expect_bcast(4'd14, 32'hF01, 1'b1);
        end
        cycle(1'b1, 4'd4, 32'hE01, 1'b1, 4'd14, 32'hF01, 1'b1, 1'b0, oa, ol);
        drain("after_rollback_drained", 8);

        // Alias zero is dropped from either source
        do_reset();
        for (int k = 0; k < 4; k++)
            cycle(1'b0, '0, '0, 1'b1, 4'd0, 32'h0BAD, 1'b1, 1'b0, oa, ol);
        cycle(1'b1, 4'd0, 32'h0BAD, 1'b0, '0, '0, 1'b1, 1'b0, oa, ol);
        idle(6);
        expect_bcast(4'd5, 32'h55, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 4'd5, 32'h55, 1'b1, 1'b0, oa, ol);
        drain("alias0_drained", 6);

        check("final_sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
